// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//
// Centisecond stopwatch with a lap hold. It counts MM:SS.CC in BCD while
// running, freezes the display on a lap request while the count keeps going,
// and flags an overflow past 99:59.99. The count either wraps or saturates
// at 99:59.99, depending on SATURATE.
//
// Parameters
//   SATURATE   : 0 = wrap to 00:00.00 after 99:59.99, 1 = hold at 99:59.99
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   tick       : one-clk-wide 100 Hz enable pulse
//   start_stop : debounced level; its rising edge starts or pauses the count
//   clear      : debounced level; its rising edge returns to idle and zeroes
//   lap        : debounced level; its rising edge enters or leaves the lap hold
//   digits     : displayed BCD value {min_t, min_o, sec_t, sec_o, cs_t, cs_o}
//   running    : high while counting (RUN or LAP)
//   lap_active : high while the display is frozen on the lap value
//   overflow   : sticky; set by a tick arriving at 99:59.99
// ---------------------------------------------------------------------------
module stopwatch_core #(
    parameter int SATURATE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int NUM_DIGITS = 6;

    // Highest legal value of each digit, least significant (cs_o) first.
    localparam logic [3:0] DIGIT_MAX [NUM_DIGITS] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd9};

    state_t      state_reg, state_next;
    logic [23:0] count_reg, count_next;
    logic [23:0] lap_hold_reg, lap_hold_next;
    logic [23:0] count_inc;
    logic        overflow_reg, overflow_next;
    logic        running_reg, lap_active_reg;

    logic        start_stop_prev_reg, clear_prev_reg, lap_prev_reg;
    logic        edge_arm_reg;
    logic        start_stop_edge, clear_edge, lap_edge;

    logic [NUM_DIGITS:0] carry;
    logic                at_top;
    logic                count_enable;

    // -----------------------------------------------------------------------
    // Rising-edge detection. edge_arm_reg stays low for the first clock after
    // reset so that a button already held down through reset release is taken
    // as the starting level rather than as a press.
    // -----------------------------------------------------------------------
    assign start_stop_edge = edge_arm_reg & start_stop & ~start_stop_prev_reg;
    assign clear_edge      = edge_arm_reg & clear      & ~clear_prev_reg;
    assign lap_edge        = edge_arm_reg & lap        & ~lap_prev_reg;

    // -----------------------------------------------------------------------
    // BCD increment: a digit advances only when every lower digit is at its
    // maximum, and rolls to 0 when it is itself at its maximum. When all six
    // digits are at their maxima the whole count rolls to 00:00.00.
    // -----------------------------------------------------------------------
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            logic       at_max;

            assign digit          = count_reg[gi*4 +: 4];
            assign at_max         = (digit == DIGIT_MAX[gi]);
            assign carry[gi+1]    = carry[gi] & at_max;
            assign count_inc[gi*4 +: 4] = !carry[gi] ? digit :
                                          (at_max ? 4'd0 : digit + 4'd1);
        end
    endgenerate

    assign at_top       = carry[NUM_DIGITS];
    assign count_enable = tick & ((state_reg == RUN) | (state_reg == LAP));

    // -----------------------------------------------------------------------
    // Next-state logic. The tick is applied against the present state, and
    // the lap hold captures the post-tick count of the entry cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        lap_hold_next = lap_hold_reg;
        overflow_next = overflow_reg;

        if (clear_edge) begin
            state_next    = IDLE;
            count_next    = '0;
            lap_hold_next = '0;
            overflow_next = 1'b0;
        end else begin
            if (count_enable) begin
                if (at_top) begin
                    overflow_next = 1'b1;
                    count_next    = (SATURATE != 0) ? count_reg : count_inc;
                end else begin
                    count_next = count_inc;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start_stop_edge) state_next = RUN;
                end
                RUN: begin
                    if (start_stop_edge) begin
                        state_next = PAUSE;
                    end else if (lap_edge) begin
                        state_next    = LAP;
                        lap_hold_next = count_next;
                    end
                end
                LAP: begin
                    if (start_stop_edge)  state_next = PAUSE;
                    else if (lap_edge)    state_next = RUN;
                end
                PAUSE: begin
                    if (start_stop_edge) state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers. running/lap_active are decoded from the next state so
    // they line up with state_reg while being pure flop outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            count_reg           <= '0;
            lap_hold_reg        <= '0;
            overflow_reg        <= 1'b0;
            running_reg         <= 1'b0;
            lap_active_reg      <= 1'b0;
            start_stop_prev_reg <= 1'b0;
            clear_prev_reg      <= 1'b0;
            lap_prev_reg        <= 1'b0;
            edge_arm_reg        <= 1'b0;
        end else begin
            state_reg           <= state_next;
            count_reg           <= count_next;
            lap_hold_reg        <= lap_hold_next;
            overflow_reg        <= overflow_next;
            running_reg         <= (state_next == RUN) || (state_next == LAP);
            lap_active_reg      <= (state_next == LAP);
            start_stop_prev_reg <= start_stop;
            clear_prev_reg      <= clear;
            lap_prev_reg        <= lap;
            edge_arm_reg        <= 1'b1;
        end
    end

    // The display selects between two registers, so it follows reset at once
    // and switches back to the live count on the clock that leaves LAP.
    assign digits     = (state_reg == LAP) ? lap_hold_reg : count_reg;
    assign running    = running_reg;
    assign lap_active = lap_active_reg;
    assign overflow   = overflow_reg;

endmodule
